// File: rtl/chrisruk_led_decoder.sv
// Two-wire LED strip deframer: turns strip clock/data into one parallel pixel word per LED frame.
// Latency: pixel_valid is high in the cycle after edge E+1, where E first samples led_clk=1 for bit 32.
// Backpressure: none; the strip stream cannot be stalled, and each strobe is a single-cycle pulse.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   led_clk, led_data strip clock and data from the matrix driver (synchronous to clk)
//   pixel_valid       one-cycle strobe; pixel_idx/bright/b/g/r are valid and then held
//   pixel_idx         LED index within the strip frame (0..LED_COUNT-1)
//   pixel_bright      5-bit global-brightness field
//   pixel_b/g/r       colour bytes, in wire order B, G, R
//   frame_done        one-cycle strobe alongside the last LED's pixel_valid
//   err               one-cycle strobe when a frame is aborted (timeout, or bad header)
//
// Optional build macro LED_HDR_CHECK_EN: require header bits 111 on every LED frame.
// A frame with any other header is aborted with err instead of producing a pixel.
module chrisruk_led_decoder #(
  parameter int LED_COUNT = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clk,
  input  logic       led_data,
  output logic       pixel_valid,
  output logic [5:0] pixel_idx,
  output logic [4:0] pixel_bright,
  output logic [7:0] pixel_b,
  output logic [7:0] pixel_g,
  output logic [7:0] pixel_r,
  output logic       frame_done,
  output logic       err
);

  localparam logic [5:0] LAST_IDX   = 6'(LED_COUNT - 1);
  localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    SYNC,
    ARMED,
    LED
  } state_t;

  state_t      state, state_nxt;
  logic        clk_q, clk_d, data_q;
  logic [5:0]  zero_cnt, zero_cnt_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [30:0] shreg, shreg_nxt;
  logic [5:0]  led_idx, led_idx_nxt;
  logic [7:0]  idle_cnt;
  logic        valid_nxt, done_nxt, err_nxt, load_pix;
  logic        bit_evt, timeout_hit, hdr_ok;
  logic [31:0] word;

  // A bit is taken on the rising edge of the registered strip clock.
  assign bit_evt = clk_q & ~clk_d;

  // The word as it stands once the current bit is shifted in; only
  // meaningful on the 32nd bit of an LED frame.
  assign word = {shreg, data_q};

  // The idle counter hits TIMEOUT on this edge; a bit event in the same
  // cycle clears it instead, so the pixel always wins over the timeout.
  assign timeout_hit = (state == LED) && !bit_evt && (idle_cnt == IDLE_LIMIT);

`ifdef LED_HDR_CHECK_EN
  assign hdr_ok = (word[31:29] == 3'b111);
`else
  // Header bits only matter when checking is compiled in.
  logic unused_hdr;
  assign unused_hdr = ^word[31:29];
  assign hdr_ok     = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    zero_cnt_nxt = zero_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    led_idx_nxt  = led_idx;
    valid_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    load_pix     = 1'b0;

    case (state)
      SYNC: begin
        led_idx_nxt = 6'd0;
        if (bit_evt) begin
          if (data_q) begin
            zero_cnt_nxt = 6'd0;
          end else if (zero_cnt == 6'd31) begin
            // 32nd consecutive zero: start frame seen.
            zero_cnt_nxt = 6'd0;
            state_nxt    = ARMED;
          end else begin
            zero_cnt_nxt = zero_cnt + 6'd1;
          end
        end
      end

      ARMED: begin
        // The first 1 after the zero run is the top header bit of LED 0.
        if (bit_evt && data_q) begin
          state_nxt   = LED;
          bit_cnt_nxt = 5'd1;
          shreg_nxt   = 31'd1;
          led_idx_nxt = 6'd0;
        end
      end

      LED: begin
        if (bit_evt) begin
          shreg_nxt = word[30:0];
          if (bit_cnt == 5'd31) begin
            bit_cnt_nxt = 5'd0;
            if (!hdr_ok) begin
              err_nxt     = 1'b1;
              led_idx_nxt = 6'd0;
              state_nxt   = SYNC;
            end else begin
              valid_nxt = 1'b1;
              load_pix  = 1'b1;
              if (led_idx == LAST_IDX) begin
                done_nxt    = 1'b1;
                led_idx_nxt = 6'd0;
                state_nxt   = SYNC;
              end else begin
                led_idx_nxt = led_idx + 6'd1;
              end
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 5'd1;
          end
        end else if (timeout_hit) begin
          // Strip clock stalled mid-frame: drop the partial LED and resync.
          err_nxt     = 1'b1;
          bit_cnt_nxt = 5'd0;
          led_idx_nxt = 6'd0;
          state_nxt   = SYNC;
        end
      end

      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      clk_q        <= 1'b0;
      clk_d        <= 1'b0;
      data_q       <= 1'b0;
      zero_cnt     <= 6'd0;
      bit_cnt      <= 5'd0;
      shreg        <= 31'd0;
      led_idx      <= 6'd0;
      idle_cnt     <= 8'd0;
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      pixel_idx    <= 6'd0;
      pixel_bright <= 5'd0;
      pixel_b      <= 8'd0;
      pixel_g      <= 8'd0;
      pixel_r      <= 8'd0;
    end else begin
      clk_q       <= led_clk;
      clk_d       <= clk_q;
      data_q      <= led_data;
      state       <= state_nxt;
      zero_cnt    <= zero_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shreg       <= shreg_nxt;
      led_idx     <= led_idx_nxt;
      pixel_valid <= valid_nxt;
      frame_done  <= done_nxt;
      err         <= err_nxt;

      if (bit_evt) begin
        idle_cnt <= 8'd0;
      end else if (idle_cnt != 8'hff) begin
        idle_cnt <= idle_cnt + 8'd1;
      end

      // Pixel fields are captured only on a strobe and held otherwise.
      if (load_pix) begin
        pixel_idx    <= led_idx;
        pixel_bright <= word[28:24];
        pixel_b      <= word[23:16];
        pixel_g      <= word[15:8];
        pixel_r      <= word[7:0];
      end
    end
  end

endmodule

// File: tb/tb_chrisruk_led_decoder.sv
`timescale 1ns/1ps
// Bench for chrisruk_led_decoder: drives strip frames bit by bit at the
// driver's 2-cycle strip-clock period and compares every decoded pixel
// against the frame contents that were sent.
module tb_chrisruk_led_decoder;
  localparam int LED_COUNT = 64;
  localparam int TIMEOUT   = 255;
`ifdef LED_HDR_CHECK_EN
  localparam bit HDR_CHECK = 1'b1;
`else
  localparam bit HDR_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [5:0] idx;
    logic [4:0] bright;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset, led_clk, led_data;
  logic       pixel_valid, frame_done, err;
  logic [5:0] pixel_idx;
  logic [4:0] pixel_bright;
  logic [7:0] pixel_b, pixel_g, pixel_r;

  chrisruk_led_decoder #(.LED_COUNT(LED_COUNT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .led_clk(led_clk), .led_data(led_data),
    .pixel_valid(pixel_valid), .pixel_idx(pixel_idx), .pixel_bright(pixel_bright),
    .pixel_b(pixel_b), .pixel_g(pixel_g), .pixel_r(pixel_r),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // Edge counter: after the n-th rising edge, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record strobes on the falling edge.
  pix_t got_q[$];
  int   got_cyc[$];
  int   fd_cnt = 0, fd_bad = 0, err_cnt = 0, err_cyc = 0, multi_cnt = 0;
  logic pv_q = 1'b0, fd_q = 1'b0, er_q = 1'b0;
  always @(negedge clk) begin
    if (pixel_valid === 1'b1) begin
      got_q.push_back({pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r});
      got_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt <= fd_cnt + 1;
      if (!(pixel_valid === 1'b1 && pixel_idx == 6'(LED_COUNT - 1))) fd_bad <= fd_bad + 1;
    end
    if (err === 1'b1) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if ((pixel_valid && pv_q) || (frame_done && fd_q) || (err && er_q)) multi_cnt <= multi_cnt + 1;
    pv_q <= pixel_valid;
    fd_q <= frame_done;
    er_q <= err;
  end

  int passed = 0, total = 0;
  logic [31:0] frame_w [LED_COUNT];
  int   word_end [LED_COUNT];
  int   last_raise = 0;
  pix_t exp_q[$];
  int   exp_fd, exp_err;
  int   base_px, base_fd, base_fdbad, base_err, base_multi;

  // ---------------- stimulus ----------------
  // One strip bit: clock low for a cycle, then high for a cycle.
  task automatic send_bit(input logic b);
    led_data = b;
    led_clk  = 1'b0;
    @(posedge clk); #1;
    led_clk    = 1'b1;
    last_raise = cyc;
    @(posedge clk); #1;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame();
    for (int i = 0; i < LED_COUNT; i++) begin
      send_word(frame_w[i]);
      word_end[i] = last_raise;
    end
  endtask

  task automatic fill_const(input logic [31:0] w);
    for (int i = 0; i < LED_COUNT; i++) frame_w[i] = w;
  endtask

  task automatic fill_random();
    logic [31:0] r;
    for (int i = 0; i < LED_COUNT; i++) begin
      r = $urandom();
      frame_w[i] = {3'b111, r[28:0]};
    end
  endtask

  // ---------------- reference model ----------------
  // Expected decode of the first n LED frames of frame_w: each LED gives
  // its index and fields; a bad header (when checked) aborts the frame.
  task automatic model_frame(input int n);
    for (int i = 0; i < n; i++) begin
      if (HDR_CHECK && frame_w[i][31:29] != 3'b111) begin
        exp_err++;
        break;
      end
      exp_q.push_back({6'(i), frame_w[i][28:24], frame_w[i][23:16],
                       frame_w[i][15:8], frame_w[i][7:0]});
      if (i == LED_COUNT - 1) exp_fd++;
    end
  endtask

  task automatic snap();
    base_px    = got_q.size();
    base_fd    = fd_cnt;
    base_fdbad = fd_bad;
    base_err   = err_cnt;
    base_multi = multi_cnt;
    exp_q.delete();
    exp_fd  = 0;
    exp_err = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; led_clk = 1'b0; led_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({pixel_valid, frame_done, err} !== 3'b000)
      $display("FAIL reset_strobes: got %b required 000", {pixel_valid, frame_done, err});
    else passed++;
    total++;
    if ({pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r} !== 35'd0)
      $display("FAIL reset_fields: got %h required 0", {pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r});
    else passed++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    snap();
    fill_const(32'hf0000f00);
    send_zeros(32);
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL single_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL single_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    // Pixel of LED 0 appears two edges after its last bit's clock transition.
    total++;
    if (got_cyc.size() <= base_px || got_cyc[base_px] !== word_end[0] + 2)
      $display("FAIL single_latency: got cycle %0d required %0d",
               (got_cyc.size() > base_px) ? got_cyc[base_px] : -1, word_end[0] + 2);
    else passed++;
    total++;
    if (fd_cnt - base_fd !== 1 || fd_bad !== base_fdbad)
      $display("FAIL single_frame_done: got %0d (misplaced %0d) required 1 (0)", fd_cnt - base_fd, fd_bad - base_fdbad);
    else passed++;
    total++;
    if (err_cnt - base_err !== 0)
      $display("FAIL single_err: got %0d required 0", err_cnt - base_err);
    else passed++;
    total++;
    if (multi_cnt !== base_multi)
      $display("FAIL single_strobe_width: got %0d long strobes required 0", multi_cnt - base_multi);
    else passed++;
    total++;
    if (pixel_valid !== 1'b0 || {pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r} !== exp_q[exp_q.size() - 1])
      $display("FAIL single_hold: got %h required %h", {pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r}, exp_q[exp_q.size() - 1]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int min_gap;
    snap();
    fill_const(32'hf0000f00);
    frame_w[5] = 32'hf0070000;
    send_zeros(32);
    send_frame();
    send_zeros(96);
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL b2b_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL b2b_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (got_q.size() <= base_px + 5 || got_q[base_px + 5].b !== 8'h07 || got_q[base_px + 5].bright !== 5'h10)
      $display("FAIL b2b_led5: got %h required B=07 bright=10",
               (got_q.size() > base_px + 5) ? got_q[base_px + 5] : 35'd0);
    else passed++;
    min_gap = 1000000;
    for (int i = base_px + 1; i < got_cyc.size(); i++)
      if (got_cyc[i] - got_cyc[i - 1] < min_gap) min_gap = got_cyc[i] - got_cyc[i - 1];
    total++;
    if (min_gap < 64)
      $display("FAIL b2b_spacing: got %0d cycles required >= 64", min_gap);
    else passed++;
    total++;
    if (fd_cnt - base_fd !== 2 || fd_bad !== base_fdbad)
      $display("FAIL b2b_frame_done: got %0d (misplaced %0d) required 2 (0)", fd_cnt - base_fd, fd_bad - base_fdbad);
    else passed++;
    total++;
    if (err_cnt - base_err !== 0)
      $display("FAIL b2b_err: got %0d required 0", err_cnt - base_err);
    else passed++;
  endtask

  task automatic test_no_false_lock();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    snap();
    fill_random();
    send_zeros(31);
    send_bit(1'b1);
    send_zeros(32);
    total++;
    if (got_q.size() !== base_px)
      $display("FAIL nolock_early: got %0d strobes required 0", got_q.size() - base_px);
    else passed++;
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL nolock_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL nolock_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (fd_cnt - base_fd !== 1 || err_cnt - base_err !== 0)
      $display("FAIL nolock_done_err: got done=%0d err=%0d required 1 0", fd_cnt - base_fd, err_cnt - base_err);
    else passed++;
  endtask

  task automatic test_timeout();
    int evt_edge;
    snap();
    fill_random();
    send_zeros(32);
    for (int i = 0; i < 3; i++) send_word(frame_w[i]);
    for (int i = 31; i >= 22; i--) send_bit(frame_w[3][i]);
    // The last bit is acted on at the edge after the cycle that sampled it;
    // the strip clock now stays high, so no further bits arrive.
    evt_edge = last_raise + 2;
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    model_frame(3);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL timeout_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL timeout_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (err_cnt - base_err !== 1)
      $display("FAIL timeout_err_count: got %0d required 1", err_cnt - base_err);
    else passed++;
    total++;
    if (err_cyc - evt_edge !== TIMEOUT)
      $display("FAIL timeout_err_time: got %0d cycles required %0d", err_cyc - evt_edge, TIMEOUT);
    else passed++;
    total++;
    if (fd_cnt - base_fd !== 0)
      $display("FAIL timeout_frame_done: got %0d required 0", fd_cnt - base_fd);
    else passed++;
    snap();
    fill_random();
    send_zeros(32);
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL timeout_next_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL timeout_next_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (fd_cnt - base_fd !== 1 || err_cnt - base_err !== 0)
      $display("FAIL timeout_next_done_err: got done=%0d err=%0d required 1 0", fd_cnt - base_fd, err_cnt - base_err);
    else passed++;
  endtask

  task automatic test_header();
    snap();
    fill_const(32'hf0000f00);
    frame_w[2] = 32'h70000f00;
    send_zeros(32);
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL header_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL header_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (fd_cnt - base_fd !== exp_fd || err_cnt - base_err !== exp_err)
      $display("FAIL header_done_err: got done=%0d err=%0d required %0d %0d",
               fd_cnt - base_fd, err_cnt - base_err, exp_fd, exp_err);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    snap();
    fill_random();
    send_zeros(32);
    for (int i = 0; i < 40; i++) send_word(frame_w[i]);
    for (int i = 31; i >= 22; i--) send_bit(frame_w[40][i]);
    model_frame(40);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL rstmid_pre_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    led_clk = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if ({pixel_valid, frame_done, err, pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r} !== 38'd0)
      $display("FAIL rstmid_outputs: got %h required 0",
               {pixel_valid, frame_done, err, pixel_idx, pixel_bright, pixel_b, pixel_g, pixel_r});
    else passed++;
    snap();
    fill_random();
    send_zeros(32);
    send_frame();
    send_zeros(64);
    model_frame(LED_COUNT);
    total++;
    if (got_q.size() - base_px !== exp_q.size())
      $display("FAIL rstmid_count: got %0d strobes required %0d", got_q.size() - base_px, exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
      total++;
      if (got_q[base_px + i] !== exp_q[i])
        $display("FAIL rstmid_pixel%0d: got %h required %h", i, got_q[base_px + i], exp_q[i]);
      else passed++;
    end
    total++;
    if (fd_cnt - base_fd !== 1 || err_cnt - base_err !== 0)
      $display("FAIL rstmid_done_err: got done=%0d err=%0d required 1 0", fd_cnt - base_fd, err_cnt - base_err);
    else passed++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 2; f++) begin
      snap();
      fill_random();
      send_zeros(32 + $urandom_range(0, 40));
      send_frame();
      send_zeros(32 + $urandom_range(0, 60));
      model_frame(LED_COUNT);
      total++;
      if (got_q.size() - base_px !== exp_q.size())
        $display("FAIL random%0d_count: got %0d strobes required %0d", f, got_q.size() - base_px, exp_q.size());
      else passed++;
      for (int i = 0; i < exp_q.size() && base_px + i < got_q.size(); i++) begin
        total++;
        if (got_q[base_px + i] !== exp_q[i])
          $display("FAIL random%0d_pixel%0d: got %h required %h", f, i, got_q[base_px + i], exp_q[i]);
        else passed++;
      end
      total++;
      if (fd_cnt - base_fd !== 1 || fd_bad !== base_fdbad || err_cnt - base_err !== 0 || multi_cnt !== base_multi)
        $display("FAIL random%0d_strobes: got done=%0d misplaced=%0d err=%0d long=%0d required 1 0 0 0", f,
                 fd_cnt - base_fd, fd_bad - base_fdbad, err_cnt - base_err, multi_cnt - base_multi);
      else passed++;
    end
  endtask

  initial begin
    reset    = 1'b1;
    led_clk  = 1'b0;
    led_data = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_no_false_lock();
    test_timeout();
    test_header();
    test_reset_mid_frame();
    test_random_frames();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
